// File: rtl/point_spawner.sv
// -----------------------------------------------------------------------------
// point_spawner
//
// Collectible-point generator and scorer for up to four players. One point
// lives on a CELL-pitch grid. When a player's box overlaps it, the point is
// awarded and hidden. A cooldown runs, then an LFSR proposes new cells, one
// per cycle. A proposal is refused when it lies off-grid, the terrain block
// reports it as blocked, or it overlaps a player. After MAX_TRIES refusals
// the point falls back to (INIT_COL, INIT_ROW). Reaching WIN_SCORE freezes
// the game until reset.
//
// Optional feature macro: POINT_SHARED_SCORE_EN
//   defined   : every player overlapping in the award cycle scores
//   undefined : only the lowest-index overlapping player scores (one-hot mask)
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   player_x/y    NUM_PLAYERS x 10-bit player centres (player i at [i*10 +: 10])
//   cand_x/y      candidate centre presented to the terrain collision block
//   cand_blocked  same-cycle terrain reply for cand_x/cand_y
//   point_x/y     active point centre
//   point_valid   point is drawable and collectable
//   scores        NUM_PLAYERS x SCORE_W scores (player i at [i*SCORE_W +: SCORE_W])
//   collect       one-cycle pulse per award
//   collect_mask  players awarded, valid with collect
//   game_over     some score reached WIN_SCORE
//   winner        lowest-index player at WIN_SCORE, valid with game_over
// -----------------------------------------------------------------------------
module point_spawner #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          GRID_COLS   = 31,
  parameter int          GRID_ROWS   = 23,
  parameter int          CELL        = 32,
  parameter int          POINT_SIZE  = 8,
  parameter int          PLAYER_SIZE = 16,
  parameter int          SCORE_W     = 5,
  parameter int          WIN_SCORE   = 20,
  parameter int          COOLDOWN    = 10000,
  parameter int          MAX_TRIES   = 64,
  parameter int          INIT_COL    = 15,
  parameter int          INIT_ROW    = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PLAYERS*10-1:0]      player_x,
  input  logic [NUM_PLAYERS*10-1:0]      player_y,
  output logic [9:0]                     cand_x,
  output logic [9:0]                     cand_y,
  input  logic                           cand_blocked,
  output logic [9:0]                     point_x,
  output logic [9:0]                     point_y,
  output logic                           point_valid,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           collect,
  output logic [NUM_PLAYERS-1:0]         collect_mask,
  output logic                           game_over,
  output logic [1:0]                     winner
);

  typedef enum logic [1:0] {ACTIVE, COOL, SPAWN, OVER} state_t;

  localparam int                COOL_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int                TRY_W     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [10:0]       HIT_RANGE = 11'(POINT_SIZE + PLAYER_SIZE);
  localparam logic [8:0]        COLS_LIM  = 9'(GRID_COLS);
  localparam logic [8:0]        ROWS_LIM  = 9'(GRID_ROWS);
  localparam logic [9:0]        INIT_X    = 10'((INIT_COL + 1) * CELL);
  localparam logic [9:0]        INIT_Y    = 10'((INIT_ROW + 1) * CELL);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);
  localparam logic [SCORE_W-1:0] WIN_LIM  = SCORE_W'(WIN_SCORE);

  // Unsigned distance on an 11-bit range so that the subtraction never wraps.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] ea;
    logic [10:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  function automatic logic boxes_overlap(input logic [9:0] ax, input logic [9:0] ay,
                                         input logic [9:0] bx, input logic [9:0] by);
    return (abs_diff(ax, bx) <= HIT_RANGE) && (abs_diff(ay, by) <= HIT_RANGE);
  endfunction

  // Grid index to pixel centre; off-grid indices are truncated but never accepted.
  function automatic logic [9:0] cell_pix(input logic [7:0] idx);
    return 10'((32'(idx) + 32'd1) * 32'(CELL));
  endfunction

  state_t                                 state_q, state_d;
  logic [15:0]                            lfsr_q;
  logic                                   lfsr_fb;
  logic [9:0]                             ptx_q, ptx_d;
  logic [9:0]                             pty_q, pty_d;
  logic                                   valid_q, valid_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]    score_q, score_d, score_inc;
  logic                                   collect_q, collect_d;
  logic [NUM_PLAYERS-1:0]                 mask_q, mask_d;
  logic                                   over_q, over_d;
  logic [1:0]                             winner_q, winner_d;
  logic [COOL_W-1:0]                      cool_q, cool_d;
  logic [TRY_W-1:0]                       try_q, try_d;

  logic [NUM_PLAYERS-1:0][9:0]            plx, ply;
  logic [NUM_PLAYERS-1:0]                 hit_point;
  logic [NUM_PLAYERS-1:0]                 hit_cand;
  logic [NUM_PLAYERS-1:0]                 award;
  logic                                   win_any;
  logic [1:0]                             win_idx;
  logic                                   cand_in_grid;
  logic                                   cand_ok;

  assign plx = player_x;
  assign ply = player_y;

  // ---- overlap and candidate evaluation --------------------------------------
  assign cand_x = cell_pix(lfsr_q[7:0]);
  assign cand_y = cell_pix(lfsr_q[15:8]);

  always_comb begin
    hit_point = '0;
    hit_cand  = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      hit_point[i] = boxes_overlap(ptx_q, pty_q, plx[i], ply[i]);
      hit_cand[i]  = boxes_overlap(cand_x, cand_y, plx[i], ply[i]);
    end
  end

  assign cand_in_grid = ({1'b0, lfsr_q[7:0]} < COLS_LIM) && ({1'b0, lfsr_q[15:8]} < ROWS_LIM);
  assign cand_ok      = cand_in_grid && !cand_blocked && !(|hit_cand);

`ifdef POINT_SHARED_SCORE_EN
  assign award = hit_point;
`else
  // Isolate the lowest set bit: x & -x.
  assign award = hit_point & (~hit_point + NUM_PLAYERS'(1));
`endif

  // ---- score update and win detection -----------------------------------------
  always_comb begin
    score_inc = score_q;
    win_any   = 1'b0;
    win_idx   = 2'd0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_inc[i] = score_q[i] + SCORE_W'(award[i]);
    end
    // Descending scan so the lowest index wins ties.
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (score_inc[i] >= WIN_LIM) begin
        win_any = 1'b1;
        win_idx = 2'(i);
      end
    end
  end

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];

  // ---- next-state decision ------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ptx_d     = ptx_q;
    pty_d     = pty_q;
    valid_d   = valid_q;
    score_d   = score_q;
    collect_d = 1'b0;
    mask_d    = '0;
    over_d    = over_q;
    winner_d  = winner_q;
    cool_d    = cool_q;
    try_d     = try_q;
    case (state_q)
      ACTIVE: begin
        if (|award) begin
          collect_d = 1'b1;
          mask_d    = award;
          score_d   = score_inc;
          valid_d   = 1'b0;
          if (win_any) begin
            state_d  = OVER;
            over_d   = 1'b1;
            winner_d = win_idx;
          end else begin
            state_d = COOL;
            cool_d  = '0;
          end
        end
      end
      COOL: begin
        if (cool_q == COOL_LAST) begin
          state_d = SPAWN;
          try_d   = '0;
        end else begin
          cool_d = cool_q + COOL_W'(1);
        end
      end
      SPAWN: begin
        if (cand_ok) begin
          ptx_d   = cand_x;
          pty_d   = cand_y;
          valid_d = 1'b1;
          state_d = ACTIVE;
        end else if (try_q == TRY_LAST) begin
          ptx_d   = INIT_X;
          pty_d   = INIT_Y;
          valid_d = 1'b1;
          state_d = ACTIVE;
        end else begin
          try_d = try_q + TRY_W'(1);
        end
      end
      OVER: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ACTIVE;
      end
    endcase
  end

  // ---- state registers ------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACTIVE;
      lfsr_q    <= LFSR_SEED;
      ptx_q     <= INIT_X;
      pty_q     <= INIT_Y;
      valid_q   <= 1'b1;
      score_q   <= '0;
      collect_q <= 1'b0;
      mask_q    <= '0;
      over_q    <= 1'b0;
      winner_q  <= 2'd0;
      cool_q    <= '0;
      try_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= {lfsr_q[14:0], lfsr_fb};
      ptx_q     <= ptx_d;
      pty_q     <= pty_d;
      valid_q   <= valid_d;
      score_q   <= score_d;
      collect_q <= collect_d;
      mask_q    <= mask_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      cool_q    <= cool_d;
      try_q     <= try_d;
    end
  end

  assign point_x      = ptx_q;
  assign point_y      = pty_q;
  assign point_valid  = valid_q;
  assign scores       = score_q;
  assign collect      = collect_q;
  assign collect_mask = mask_q;
  assign game_over    = over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_point_spawner.sv
`timescale 1ns/1ps
module tb_point_spawner;
  localparam int NP  = 2;
  localparam int SW  = 5;
  localparam int CD  = 4;
  localparam int MT  = 64;
  localparam int WIN = 20;
  localparam int FAR = 1023;

  localparam int PH_ACT   = 0;
  localparam int PH_COOL  = 1;
  localparam int PH_SPAWN = 2;
  localparam int PH_OVER  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP*10-1:0]  player_x = '0;
  logic [NP*10-1:0]  player_y = '0;
  logic [9:0]        cand_x, cand_y;
  logic              cand_blocked = 1'b0;
  logic [9:0]        point_x, point_y;
  logic              point_valid;
  logic [NP*SW-1:0]  scores;
  logic              collect;
  logic [NP-1:0]     collect_mask;
  logic              game_over;
  logic [1:0]        winner;

  point_spawner #(.NUM_PLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(WIN),
                  .COOLDOWN(CD), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .player_x(player_x), .player_y(player_y),
    .cand_x(cand_x), .cand_y(cand_y), .cand_blocked(cand_blocked),
    .point_x(point_x), .point_y(point_y), .point_valid(point_valid),
    .scores(scores), .collect(collect), .collect_mask(collect_mask),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int pxv[NP];
  int pyv[NP];

  // Reference model state
  int m_phase, m_px, m_py, m_valid, m_collect, m_mask, m_over, m_winner;
  int m_lfsr, m_edge, m_spawn_edge, m_tries;
  int m_sc[NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit near(input int ax, input int ay, input int bx, input int by);
    int dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return (dx <= 24) && (dy <= 24);
  endfunction

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 14) ^ (l >> 12) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 32'hFFFF;
  endfunction

  task automatic set_player(input int i, input int x, input int y);
    pxv[i] = x;
    pyv[i] = y;
    player_x[i*10 +: 10] = 10'(x);
    player_y[i*10 +: 10] = 10'(y);
  endtask

  task automatic model_reset();
    m_phase = PH_ACT; m_px = 512; m_py = 64; m_valid = 1;
    m_collect = 0; m_mask = 0; m_over = 0; m_winner = 0;
    m_lfsr = 32'hACE1; m_edge = 0; m_spawn_edge = 0; m_tries = 0;
    for (int i = 0; i < NP; i++) m_sc[i] = 0;
  endtask

  task automatic model_step();
    int hits, col, row, w;
    bit ok;
    m_collect = 0;
    m_mask = 0;
    case (m_phase)
      PH_ACT: begin
        hits = 0;
        for (int i = 0; i < NP; i++)
          if (near(m_px, m_py, pxv[i], pyv[i])) hits |= (1 << i);
        if (hits != 0) begin
`ifdef POINT_SHARED_SCORE_EN
          m_mask = hits;
`else
          for (int i = 0; i < NP; i++)
            if (m_mask == 0 && ((hits >> i) & 1) == 1) m_mask = 1 << i;
`endif
          m_collect = 1;
          m_valid = 0;
          for (int i = 0; i < NP; i++) if (((m_mask >> i) & 1) == 1) m_sc[i]++;
          w = -1;
          for (int i = 0; i < NP; i++) if (w < 0 && m_sc[i] >= WIN) w = i;
          if (w >= 0) begin
            m_phase = PH_OVER; m_over = 1; m_winner = w;
          end else begin
            m_phase = PH_COOL; m_spawn_edge = m_edge + CD;
          end
        end
      end
      PH_COOL: begin
        if (m_edge == m_spawn_edge) begin m_phase = PH_SPAWN; m_tries = 0; end
      end
      PH_SPAWN: begin
        col = m_lfsr & 255;
        row = (m_lfsr >> 8) & 255;
        ok = (col < 31) && (row < 23) && !cand_blocked;
        for (int i = 0; i < NP; i++)
          if (near((col + 1) * 32, (row + 1) * 32, pxv[i], pyv[i])) ok = 0;
        if (ok) begin
          m_px = (col + 1) * 32; m_py = (row + 1) * 32; m_valid = 1; m_phase = PH_ACT;
        end else begin
          m_tries++;
          if (m_tries == MT) begin
            m_px = 512; m_py = 64; m_valid = 1; m_phase = PH_ACT;
          end
        end
      end
      default: ;
    endcase
    m_lfsr = lfsr_next(m_lfsr);
    m_edge++;
  endtask

  task automatic check_outputs();
    int col, row;
    chk("point_valid", 32'(point_valid), 32'(m_valid));
    if (m_valid != 0) begin
      chk("point_x", 32'(point_x), 32'(m_px));
      chk("point_y", 32'(point_y), 32'(m_py));
      chk("point_in_grid", 32'(point_x <= 10'd992 && point_y <= 10'd736), 32'd1);
    end
    chk("collect", 32'(collect), 32'(m_collect));
    chk("collect_mask", 32'(collect_mask), 32'(m_mask));
    for (int i = 0; i < NP; i++) chk("score", 32'(scores[i*SW +: SW]), 32'(m_sc[i]));
    chk("game_over", 32'(game_over), 32'(m_over));
    if (m_over != 0) chk("winner", 32'(winner), 32'(m_winner));
    if (m_phase == PH_SPAWN) begin
      col = m_lfsr & 255;
      row = (m_lfsr >> 8) & 255;
      if (col < 31 && row < 23) begin
        chk("cand_x", 32'(cand_x), 32'((col + 1) * 32));
        chk("cand_y", 32'(cand_y), 32'((row + 1) * 32));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cand_blocked = 1'b0;
    for (int i = 0; i < NP; i++) set_player(i, FAR, FAR);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    int p0x, p0y, p1x, p1y;
    int exp_collect, exp_mask, exp_s0, exp_s1;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int budget;
    int r, x, y;

    vecs[0] = '{512, 64, 32, 32, 1, 1, 1, 0};
    vecs[1] = '{536, 64, 32, 32, 1, 1, 1, 0};
    vecs[2] = '{537, 64, 32, 32, 0, 0, 0, 0};
    vecs[3] = '{488, 88, 32, 32, 1, 1, 1, 0};
    vecs[4] = '{487, 64, 32, 32, 0, 0, 0, 0};
    vecs[5] = '{512, 89, 32, 32, 0, 0, 0, 0};
    vecs[6] = '{32, 32, 512, 40, 1, 2, 0, 1};
`ifdef POINT_SHARED_SCORE_EN
    vecs[7] = '{512, 64, 512, 64, 1, 3, 1, 1};
`else
    vecs[7] = '{512, 64, 512, 64, 1, 1, 1, 0};
`endif
    vecs[8] = '{1023, 64, 0, 64, 0, 0, 0, 0};
    vecs[9] = '{1000, 1000, 500, 76, 1, 2, 0, 1};

    // Reset values
    do_reset();
    chk("rst_point_x", 32'(point_x), 32'd512);
    chk("rst_point_y", 32'(point_y), 32'd64);
    chk("rst_valid", 32'(point_valid), 32'd1);
    chk("rst_scores", 32'(scores), 32'd0);
    chk("rst_collect", 32'(collect), 32'd0);
    chk("rst_mask", 32'(collect_mask), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);

    // Table: single award from the reset point
    for (int v = 0; v < 10; v++) begin
      do_reset();
      set_player(0, vecs[v].p0x, vecs[v].p0y);
      set_player(1, vecs[v].p1x, vecs[v].p1y);
      cycle();
      chk("vec_collect", 32'(collect), 32'(vecs[v].exp_collect));
      chk("vec_mask", 32'(collect_mask), 32'(vecs[v].exp_mask));
      chk("vec_s0", 32'(scores[0 +: SW]), 32'(vecs[v].exp_s0));
      chk("vec_s1", 32'(scores[SW +: SW]), 32'(vecs[v].exp_s1));
      chk("vec_valid", 32'(point_valid), 32'(1 - vecs[v].exp_collect));
    end

    // Point stays hidden through cooldown and the first spawn cycle
    do_reset();
    set_player(0, 512, 64);
    set_player(1, 32, 32);
    cycle();
    chk("cd_collect", 32'(collect), 32'd1);
    set_player(0, 512, 64);
    for (int k = 0; k < CD; k++) begin
      cycle();
      chk("cd_valid_low", 32'(point_valid), 32'd0);
      chk("cd_no_recollect", 32'(collect), 32'd0);
    end
    chk("cd_score_once", 32'(scores[0 +: SW]), 32'd1);

    // Terrain always blocked: fallback after MAX_TRIES spawn cycles
    do_reset();
    set_player(0, 512, 64);
    set_player(1, FAR, FAR);
    cycle();
    set_player(0, FAR, FAR);
    cand_blocked = 1'b1;
    for (int k = 0; k < CD + MT - 1; k++) cycle();
    chk("blk_still_hidden", 32'(point_valid), 32'd0);
    cycle();
    chk("blk_valid", 32'(point_valid), 32'd1);
    chk("blk_x", 32'(point_x), 32'd512);
    chk("blk_y", 32'(point_y), 32'd64);
    cand_blocked = 1'b0;

    // Asynchronous reset during cooldown
    do_reset();
    set_player(0, 512, 64);
    cycle();
    set_player(0, FAR, FAR);
    cycle();
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(point_valid), 32'd1);
    chk("arst_x", 32'(point_x), 32'd512);
    chk("arst_y", 32'(point_y), 32'd64);
    chk("arst_scores", 32'(scores), 32'd0);
    chk("arst_collect", 32'(collect), 32'd0);
    model_reset();
    cycle();
    rst = 1'b0;

    // Player 0 collects until the game ends
    do_reset();
    budget = 0;
    while (m_over == 0 && budget < 4000) begin
      if (m_valid != 0) set_player(0, m_px, m_py); else set_player(0, FAR, FAR);
      set_player(1, FAR, FAR);
      cand_blocked = 1'b0;
      cycle();
      budget++;
    end
    chk("win_budget", 32'(budget < 4000), 32'd1);
    chk("win_game_over", 32'(game_over), 32'd1);
    chk("win_winner", 32'(winner), 32'd0);
    chk("win_s0", 32'(scores[0 +: SW]), 32'd20);
    chk("win_s1", 32'(scores[SW +: SW]), 32'd0);
    set_player(0, m_px, m_py);
    set_player(1, m_px, m_py);
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("over_no_collect", 32'(collect), 32'd0);
      chk("over_s0_frozen", 32'(scores[0 +: SW]), 32'd20);
      chk("over_hidden", 32'(point_valid), 32'd0);
    end

    // Randomized run against the reference model
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int n = 0; n < 800; n++) begin
        for (int i = 0; i < NP; i++) begin
          r = int'($urandom_range(0, 2));
          if (r == 0) begin
            x = m_px + int'($urandom_range(0, 60)) - 30;
            y = m_py + int'($urandom_range(0, 60)) - 30;
          end else begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
          end
          if (x < 0) x = 0;
          if (x > 1023) x = 1023;
          if (y < 0) y = 0;
          if (y > 1023) y = 1023;
          set_player(i, x, y);
        end
        cand_blocked = ($urandom_range(0, 3) == 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/point_spawner.md
# point_spawner

Multi-player collectible-point generator and scorer for the game-logic layer. It places one point on a grid and detects when a player's box overlaps it. It then awards the score, enforces a respawn cooldown and picks a new grid cell from an LFSR, rejecting cells that are blocked or occupied. It sits between the player-movement blocks and the VGA draw/score overlay, and supports up to four players.

## Interface
- NUM_PLAYERS, 2: number of players, 2..4.
- GRID_COLS, 31: legal point columns, ≤256.
- GRID_ROWS, 23: legal point rows, ≤256.
- CELL, 32: pixel pitch of the grid. Cell (c,r) is centred at x=(c+1)·CELL, y=(r+1)·CELL.
- POINT_SIZE, 8; PLAYER_SIZE, 16: half-extents in pixels.
- SCORE_W, 5: width of each score.
- WIN_SCORE, 20: score that ends the game; must be < 2^SCORE_W.
- COOLDOWN, 10000: idle cycles between collect and respawn attempt; ≥1.
- MAX_TRIES, 64: spawn attempts before fallback.
- INIT_COL, 15; INIT_ROW, 1: reset and fallback cell, giving (512,64).
- LFSR_SEED, 16'hACE1: must be nonzero.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- player_x  in  NUM_PLAYERS×10  player centre x.
- player_y  in  NUM_PLAYERS×10  player centre y.
- cand_x, cand_y  out  10 each  candidate centre, sent to the external terrain collision block.
- cand_blocked  in  1  combinational reply for cand_x/cand_y, valid in the same cycle.
- point_x, point_y  out  10 each  active point centre.
- point_valid  out  1  point is drawable and collectable.
- scores  out  NUM_PLAYERS×SCORE_W  per-player scores.
- collect  out  1  one-cycle pulse on each award.
- collect_mask  out  NUM_PLAYERS  players awarded; valid with collect.
- game_over  out  1  some score ≥ WIN_SCORE.
- winner  out  2  lowest-index player at WIN_SCORE; valid with game_over.

## Operation
- FSM states: ACTIVE, COOL, SPAWN, OVER.
- Overlap of player i: |point_x−player_x[i]| ≤ POINT_SIZE+PLAYER_SIZE and likewise for y. Compute with 11-bit unsigned absolute difference; no wrap at screen edges.
- ACTIVE:
  - If any player overlaps, register collect=1 and collect_mask, increment the awarded scores and set point_valid=0.
  - Go to OVER if any new score ≥ WIN_SCORE, otherwise to COOL with the counter cleared.
- COOL: count COOLDOWN cycles, then go to SPAWN with the try counter cleared.
- SPAWN, one candidate per cycle:
  - col=lfsr[7:0], row=lfsr[15:8].
  - Reject if col≥GRID_COLS, row≥GRID_ROWS, cand_blocked=1, or the candidate overlaps any player (same overlap test).
  - On accept, latch point_x/y and go to ACTIVE with point_valid=1 next cycle.
  - After MAX_TRIES rejects, place INIT_COL/INIT_ROW regardless and go to ACTIVE.
- OVER: point_valid=0, scores frozen, no collect. Leave only by rst.
- LFSR: 16-bit Fibonacci, taps 16,15,13,4. Shifts every cycle in every state.
- Scores never wrap. Increment only from ACTIVE; the WIN_SCORE bound guarantees no overflow.

## Timing
- Reset values:
  - state=ACTIVE, point at (INIT_COL,INIT_ROW) giving (512,64), point_valid=1.
  - scores=0, collect=0, collect_mask=0, game_over=0, winner=0, lfsr=LFSR_SEED, counters=0.
- Collect latency: overlap present at edge N → collect pulses and scores update after edge N, and point_valid=0 in the same cycle.
- The first SPAWN cycle is exactly COOLDOWN+1 cycles after the collect edge. An accepted candidate is visible one cycle after its SPAWN cycle.
- Overlap during COOL, SPAWN or OVER has no effect. Overlap held in ACTIVE awards exactly once, because the state leaves ACTIVE.
- rst asserted mid-COOL or mid-SPAWN aborts immediately to the reset values.

## Configuration
- POINT_SHARED_SCORE_EN defined: every player overlapping in the award cycle scores, and collect_mask may have multiple bits.
- Not defined: only the lowest-index overlapping player scores, and collect_mask is one-hot.

## Test plan
- Reset, then hold player0 at (512,64) and player1 at (32,32) → collect at the first clock, scores[0]=1, collect_mask=01, point_valid=0 for ≥COOLDOWN+1 cycles.
- Players 0 and 1 both at (512,64) on the same cycle → with the macro, both scores are 1 and mask=11. Without it, scores are 1/0 and mask=01.
- cand_blocked tied to 1 → after MAX_TRIES SPAWN cycles the point returns to (512,64) with point_valid=1.
- Spawn with the LFSR forced to give col=40 → candidate rejected; no accepted point ever has x>992 or y>736.
- Player0 collects 20 times (COOLDOWN=4 for speed) → game_over=1, winner=0, later overlaps leave scores at 20.
- Assert rst during COOL → outputs take their reset values asynchronously, before the next clk edge.
